// File: rtl/life_pixel_renderer_pkg.sv
// Shared constants for the Life board pixel renderer: VGA geometry, board shape and
// RGB 3-3-2 colours.
package life_pixel_renderer_pkg;

  localparam int unsigned VgaWidth    = 640;
  localparam int unsigned VgaHeight   = 480;
  localparam int unsigned GridColsDef = 32;
  localparam int unsigned CellSizeDef = VgaWidth / GridColsDef;
  localparam int unsigned GridRowsDef = VgaHeight / CellSizeDef;

  localparam logic [7:0] RgbAlive  = 8'b000_111_00;
  localparam logic [7:0] RgbDead   = 8'b000_000_00;
  localparam logic [7:0] RgbGrid   = 8'b010_010_01;
  localparam logic [7:0] RgbCursor = 8'b111_000_00;
  localparam logic [7:0] RgbBlank  = 8'b000_000_00;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/life_cell_counter.sv
// One screen axis: pixel-within-cell counter plus a cell index that saturates at
// NumCells, so pixels past the board never alias back onto it.
module life_cell_counter
  import life_pixel_renderer_pkg::*;
#(
  parameter int unsigned CellSize = CellSizeDef,
  parameter int unsigned NumCells = GridColsDef,
  localparam int unsigned PixW    = clog2(CellSize),
  localparam int unsigned CellW   = clog2(NumCells + 1)
) (
  input  logic             clock_25mhz,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [PixW-1:0]  pix_o,
  output logic [CellW-1:0] cell_o,
  output logic [CellW-1:0] cell_d_o
);

  logic [PixW-1:0]  pix_q, pix_d;
  logic [CellW-1:0] cell_q, cell_d;

  always_comb begin
    pix_d  = pix_q;
    cell_d = cell_q;
    if (clear_i) begin
      pix_d  = '0;
      cell_d = '0;
    end else if (incr_i) begin
      if (pix_q == PixW'(CellSize - 1)) begin
        pix_d = '0;
        if (cell_q != CellW'(NumCells)) begin
          cell_d = cell_q + 1'b1;
        end
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      pix_q  <= '0;
      cell_q <= '0;
    end else begin
      pix_q  <= pix_d;
      cell_q <= cell_d;
    end
  end

  assign pix_o    = pix_q;
  assign cell_o   = cell_q;
  assign cell_d_o = cell_d;

endmodule

// File: rtl/life_pixel_renderer.sv
// Renders the Life board as RGB 3-3-2 with grid and cursor overlays; three-stage
// pipeline keeps the delayed syncs aligned with the colour output.
module life_pixel_renderer
  import life_pixel_renderer_pkg::*;
#(
  parameter int unsigned CELL_SIZE  = CellSizeDef,
  parameter int unsigned GRID_COLS  = GridColsDef,
  parameter int unsigned GRID_ROWS  = GridRowsDef,
  parameter bit          SHOW_GRID  = 1'b1,
  parameter logic [7:0]  ALIVE_RGB  = RgbAlive,
  parameter logic [7:0]  DEAD_RGB   = RgbDead,
  parameter logic [7:0]  GRID_RGB   = RgbGrid,
  parameter logic [7:0]  CURSOR_RGB = RgbCursor
) (
  input  logic                 clock_25mhz,
  input  logic                 reset,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 inside_video_in,
  input  logic [9:0]           x_position,
  input  logic [8:0]           y_position,
  output logic [4:0]           row_address,
  input  logic [GRID_COLS-1:0] row_data,
  input  logic [4:0]           cursor_x,
  input  logic [4:0]           cursor_y,
  input  logic                 cursor_enable,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic [7:0]           rgb,
  output logic                 frame_done
);

  localparam int unsigned PixW = clog2(CELL_SIZE);
  localparam int unsigned CxW  = clog2(GRID_COLS + 1);
  localparam int unsigned CyW  = clog2(GRID_ROWS + 1);
  localparam int unsigned ColW = clog2(GRID_COLS);

  logic line_start;
  assign line_start = inside_video_in && (x_position == '0);

  // Counter registers are the S1 cell coordinates.
  logic [PixW-1:0] px1, py1;
  logic [CxW-1:0]  cx1, unused_cx_d;
  logic [CyW-1:0]  cy1, cy_d;

  life_cell_counter #(
    .CellSize (CELL_SIZE),
    .NumCells (GRID_COLS)
  ) u_x_counter (
    .clock_25mhz (clock_25mhz),
    .reset       (reset),
    .clear_i     (line_start),
    .incr_i      (inside_video_in && (x_position != '0)),
    .pix_o       (px1),
    .cell_o      (cx1),
    .cell_d_o    (unused_cx_d)
  );

  life_cell_counter #(
    .CellSize (CELL_SIZE),
    .NumCells (GRID_ROWS)
  ) u_y_counter (
    .clock_25mhz (clock_25mhz),
    .reset       (reset),
    .clear_i     (line_start && (y_position == '0)),
    .incr_i      (line_start && (y_position != '0)),
    .pix_o       (py1),
    .cell_o      (cy1),
    .cell_d_o    (cy_d)
  );

  logic            hs1_q, vs1_q, in1_q;
  logic [4:0]      row_address_q, row_address_d;
  logic            hs2_q, vs2_q, in2_q;
  logic [PixW-1:0] px2_q, py2_q, py3_q;
  logic [CxW-1:0]  cx2_q;
  logic [CyW-1:0]  cy2_q, cy3_q;
  logic            hs3_q, vs3_q, in3_q;
  logic [7:0]      rgb_q, rgb_d;
  logic            frame_done_q, frame_done_d;
  logic [4:0]      cur_x_q, cur_y_q;
  logic            cur_en_q;
  logic            cursor_hit, on_border, on_grid;

  // Address follows the counter next-state so RAM data lands while the pixel is in S2.
  always_comb begin
    if (cy_d >= CyW'(GRID_ROWS)) begin
      row_address_d = 5'(GRID_ROWS - 1);
    end else begin
      row_address_d = 5'(cy_d);
    end
  end

  always_comb begin
    on_border = (px2_q == '0) || (px2_q == PixW'(CELL_SIZE - 1)) ||
                (py2_q == '0) || (py2_q == PixW'(CELL_SIZE - 1));
    cursor_hit = cur_en_q && (cx2_q == CxW'(cur_x_q)) && (cy2_q == CyW'(cur_y_q)) && on_border;
    on_grid = SHOW_GRID && ((px2_q == '0) || (py2_q == '0));
    rgb_d = DEAD_RGB;
    if (!in2_q) begin
      rgb_d = RgbBlank;
    end else if ((cx2_q >= CxW'(GRID_COLS)) || (cy2_q >= CyW'(GRID_ROWS))) begin
      rgb_d = RgbBlank;
    end else if (cursor_hit) begin
      rgb_d = CURSOR_RGB;
    end else if (on_grid) begin
      rgb_d = GRID_RGB;
    end else if (row_data[cx2_q[ColW-1:0]]) begin
      rgb_d = ALIVE_RGB;
    end
  end

  // Fires on the S3 visible-to-blank edge of the last board line.
  assign frame_done_d = in3_q && !in2_q && (cy3_q == CyW'(GRID_ROWS - 1)) &&
                        (py3_q == PixW'(CELL_SIZE - 1));

  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      in1_q         <= 1'b0;
      row_address_q <= '0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      in2_q         <= 1'b0;
      px2_q         <= '0;
      cx2_q         <= '0;
      py2_q         <= '0;
      cy2_q         <= '0;
      hs3_q         <= 1'b0;
      vs3_q         <= 1'b0;
      in3_q         <= 1'b0;
      py3_q         <= '0;
      cy3_q         <= '0;
      rgb_q         <= '0;
      frame_done_q  <= 1'b0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      cur_en_q      <= 1'b0;
    end else begin
      hs1_q         <= h_sync_in;
      vs1_q         <= v_sync_in;
      in1_q         <= inside_video_in;
      row_address_q <= row_address_d;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      in2_q         <= in1_q;
      px2_q         <= px1;
      cx2_q         <= cx1;
      py2_q         <= py1;
      cy2_q         <= cy1;
      hs3_q         <= hs2_q;
      vs3_q         <= vs2_q;
      in3_q         <= in2_q;
      py3_q         <= py2_q;
      cy3_q         <= cy2_q;
      rgb_q         <= rgb_d;
      frame_done_q  <= frame_done_d;
      if (frame_done_q) begin
        cur_x_q  <= cursor_x;
        cur_y_q  <= cursor_y;
        cur_en_q <= cursor_enable;
      end
    end
  end

  assign row_address = row_address_q;
  assign h_sync_out  = hs3_q;
  assign v_sync_out  = vs3_q;
  assign rgb         = rgb_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_life_pixel_renderer.sv
// Directed bench: compressed VGA frames drive a grid and a no-grid renderer; a
// scoreboard queue holds expected outputs for the 3-cycle pipeline.
module tb_life_pixel_renderer;

  logic        clock_25mhz = 1'b0;
  logic        reset;
  logic        h_sync_in, v_sync_in, inside_video_in;
  logic [9:0]  x_position;
  logic [8:0]  y_position;
  logic [4:0]  cursor_x, cursor_y;
  logic        cursor_enable;
  logic [4:0]  row_address_g, row_address_n;
  logic [31:0] ram_g, ram_n;
  logic        h_sync_out_g, v_sync_out_g, frame_done_g;
  logic        h_sync_out_n, v_sync_out_n, frame_done_n;
  logic [7:0]  rgb_g, rgb_n;

  logic [31:0] board [24];

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] rgb_g;
    logic [7:0] rgb_n;
    logic       fd;
    logic       chk_rgb;
    logic       chk_fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   pulses;
  bit   clean;
  bit   prev_vis;
  int   prev_y;
  bit   cur_en_l;
  int   cur_x_l, cur_y_l;

  always #20 clock_25mhz = ~clock_25mhz;

  always @(posedge clock_25mhz) begin
    ram_g <= board[row_address_g];
    ram_n <= board[row_address_n];
  end

  life_pixel_renderer #(.SHOW_GRID(1'b1)) dut_g (
    .clock_25mhz     (clock_25mhz),
    .reset           (reset),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .inside_video_in (inside_video_in),
    .x_position      (x_position),
    .y_position      (y_position),
    .row_address     (row_address_g),
    .row_data        (ram_g),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .cursor_enable   (cursor_enable),
    .h_sync_out      (h_sync_out_g),
    .v_sync_out      (v_sync_out_g),
    .rgb             (rgb_g),
    .frame_done      (frame_done_g)
  );

  life_pixel_renderer #(.SHOW_GRID(1'b0)) dut_n (
    .clock_25mhz     (clock_25mhz),
    .reset           (reset),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .inside_video_in (inside_video_in),
    .x_position      (x_position),
    .y_position      (y_position),
    .row_address     (row_address_n),
    .row_data        (ram_n),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .cursor_enable   (cursor_enable),
    .h_sync_out      (h_sync_out_n),
    .v_sync_out      (v_sync_out_n),
    .rgb             (rgb_n),
    .frame_done      (frame_done_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rgb(input bit grid, input bit vis, input int x,
                                           input int y);
    int cx, cy, px, py;
    if (!vis) return 8'h00;
    cx = x / 20;
    cy = y / 20;
    px = x % 20;
    py = y % 20;
    if (cx >= 32 || cy >= 24) return 8'h00;
    if (cur_en_l && cx == cur_x_l && cy == cur_y_l &&
        (px == 0 || px == 19 || py == 0 || py == 19)) return 8'b111_000_00;
    if (grid && (px == 0 || py == 0)) return 8'b010_010_01;
    if (board[cy][cx]) return 8'b000_111_00;
    return 8'b000_000_00;
  endfunction

  function automatic bit full_line(input int y);
    return y inside {0, 1, 19, 20, 59, 60, 61, 70, 79, 80, 459, 460, 461, 470, 478, 479};
  endfunction

  task automatic step(input bit vis, input int x, input int y, input bit hs, input bit vs);
    exp_t e;
    int   ra;
    h_sync_in       = hs;
    v_sync_in       = vs;
    inside_video_in = vis;
    x_position      = 10'(x);
    y_position      = 9'(y);
    e.hs      = hs;
    e.vs      = vs;
    e.rgb_g   = model_rgb(1'b1, vis, x, y);
    e.rgb_n   = model_rgb(1'b0, vis, x, y);
    e.fd      = prev_vis && (prev_y == 479) && !vis;
    e.chk_rgb = clean || !vis;
    e.chk_fd  = clean;
    prev_vis  = vis;
    prev_y    = y;
    q.push_back(e);
    @(posedge clock_25mhz);
    #1;
    if (vis && clean) begin
      ra = (y / 20 > 23) ? 23 : y / 20;
      chk("row_address_g", 32'(row_address_g), 32'(ra));
      chk("row_address_n", 32'(row_address_n), 32'(ra));
    end
    if (frame_done_g === 1'b1) pulses++;
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("h_sync_out_g", 32'(h_sync_out_g), 32'(e.hs));
      chk("v_sync_out_g", 32'(v_sync_out_g), 32'(e.vs));
      chk("h_sync_out_n", 32'(h_sync_out_n), 32'(e.hs));
      chk("v_sync_out_n", 32'(v_sync_out_n), 32'(e.vs));
      if (e.chk_rgb) begin
        chk("rgb_grid", 32'(rgb_g), 32'(e.rgb_g));
        chk("rgb_nogrid", 32'(rgb_n), 32'(e.rgb_n));
      end
      if (e.chk_fd) begin
        chk("frame_done_g", 32'(frame_done_g), 32'(e.fd));
        chk("frame_done_n", 32'(frame_done_n), 32'(e.fd));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rgb_g"}, 32'(rgb_g), 32'h0);
    chk({tag, "_rgb_n"}, 32'(rgb_n), 32'h0);
    chk({tag, "_hs_g"}, 32'(h_sync_out_g), 32'h0);
    chk({tag, "_vs_g"}, 32'(v_sync_out_g), 32'h0);
    chk({tag, "_hs_n"}, 32'(h_sync_out_n), 32'h0);
    chk({tag, "_vs_n"}, 32'(v_sync_out_n), 32'h0);
    chk({tag, "_row_g"}, 32'(row_address_g), 32'h0);
    chk({tag, "_fd_g"}, 32'(frame_done_g), 32'h0);
    chk({tag, "_fd_n"}, 32'(frame_done_n), 32'h0);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    check_zero("midrst_async");
    @(posedge clock_25mhz);
    @(posedge clock_25mhz);
    #1;
    check_zero("midrst_held");
    reset    = 1'b0;
    q.delete();
    clean    = 1'b0;
    prev_vis = 1'b0;
    cur_en_l = 1'b0;
    cur_x_l  = 0;
    cur_y_l  = 0;
  endtask

  // One compressed frame: full lines only where the checks need them, short lines elsewhere.
  task automatic frame(input bit do_reset, input bit cur_change, input bit new_en);
    int len;
    pulses = 0;
    clean  = 1'b1;
    for (int y = 0; y < 480; y++) begin
      if (do_reset && y == 200) mid_reset();
      if (cur_change && y == 200) begin
        cursor_x      = 5'd31;
        cursor_y      = 5'd23;
        cursor_enable = new_en;
      end
      len = full_line(y) ? 640 : 4;
      for (int x = 0; x < len; x++) step(1'b1, x, y, 1'b1, 1'b1);
      for (int b = 0; b < 4; b++) step(1'b0, 0, y, !(b == 1 || b == 2), 1'b1);
    end
    cur_en_l = cursor_enable;
    cur_x_l  = int'(cursor_x);
    cur_y_l  = int'(cursor_y);
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 8; b++) step(1'b0, 0, 480 + l, !(b == 2 || b == 3), l != 1);
    end
    if (clean) chk("frame_done_pulses", 32'(pulses), 32'd1);
  endtask

  initial begin
    for (int r = 0; r < 24; r++) board[r] = 32'h0;
    board[3][5]   = 1'b1;
    board[23][31] = 1'b1;
    board[0][0]   = 1'b1;
    reset           = 1'b1;
    h_sync_in       = 1'b1;
    v_sync_in       = 1'b1;
    inside_video_in = 1'b0;
    x_position      = '0;
    y_position      = '0;
    cursor_x        = '0;
    cursor_y        = '0;
    cursor_enable   = 1'b0;
    prev_vis        = 1'b0;
    prev_y          = 0;
    cur_en_l        = 1'b0;
    cur_x_l         = 0;
    cur_y_l         = 0;
    clean           = 1'b1;
    repeat (3) @(posedge clock_25mhz);
    #1;
    check_zero("reset");
    reset = 1'b0;

    frame(1'b0, 1'b1, 1'b1);  // cursor enabled mid-frame; visible from next frame
    frame(1'b0, 1'b1, 1'b0);  // cursor drawn; disabled mid-frame
    frame(1'b1, 1'b0, 1'b0);  // reset at y=200
    frame(1'b0, 1'b0, 1'b0);  // clean frame after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
